vga_timing_controller: RTL
==========================

VGA_TIMING_CONTROLLER -- requirements
Module: vga_timing_controller

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  H_ACTIVE 640 visible pixels/line; H_FP 16 front porch; H_SYNC 96 sync width; H_BP 48 back porch (line total 800)
  V_ACTIVE 480 visible lines/frame; V_FP 10; V_SYNC 2; V_BP 33 (frame total 525)
REQ-002 Ports (name direction width meaning), clock and reset first:
  clk  input  1  pixel clock, 25 MHz; all state changes on rising edge
  reset  input  1  synchronous, active-high reset
  upd_req  input  1  game logic requests maze/framebuffer update window
  upd_done  input  1  one-cycle pulse, game logic finished its update
  h_count  output  10  horizontal position 0..799
  v_count  output  10  vertical position 0..524
  hsync  output  1  horizontal sync, active low
  vsync  output  1  vertical sync, active low
  video_on  output  1  high when h_count<640 and v_count<480
  frame_start  output  1  one-cycle pulse when counts wrap to (0,0)
  upd_grant  output  1  game logic owns framebuffer write port
  upd_abort  output  1  one-cycle pulse, grant revoked by window close
REQ-003 Only one clock; reset is synchronous and active-high; no asynchronous logic.

Function
REQ-004 h_count SHALL increment by 1 every clk; at 799 it SHALL wrap to 0 on the next edge.
REQ-005 v_count SHALL increment on the same edge that h_count wraps 799->0; at v_count 524 with h wrap, v_count SHALL wrap to 0.
REQ-006 hsync SHALL be 0 exactly for h_count 656..751, else 1; vsync SHALL be 0 exactly for v_count 490..491, else 1.
REQ-007 hsync, vsync, video_on SHALL be registered, computed from next-state counts, so each is valid in the same cycle as the h_count/v_count it decodes (zero skew, glitch-free).
REQ-008 frame_start SHALL be 1 for exactly one cycle, the cycle where (h_count,v_count)=(0,0) following a wrap from (799,524); it SHALL NOT pulse on reset release.
REQ-009 Vertical phase FSM states: V_ACT (v 0..479), V_FP (480..489), V_SYNC (490..491), V_BP (492..524); transitions coincide with v_count changes.
REQ-010 Update window = v_count>=480 (V_FP, V_SYNC, V_BP); window closes on the edge entering (0,0).
REQ-011 Grant FSM states: IDLE, GRANTED, DONE.
REQ-012 IDLE->GRANTED when upd_req=1 sampled in window and current cycle is not (799,524); upd_grant=1 from next cycle.
REQ-013 upd_req high outside the window SHALL be held pending (no grant) until the window opens; grant then issues one cycle after the first in-window sample.
REQ-014 GRANTED->DONE on upd_done=1 or upd_req=0; upd_grant=0 from next cycle.
REQ-015 GRANTED at window close SHALL drop upd_grant on the edge entering (0,0), pulse upd_abort for that one cycle, return to IDLE.
REQ-016 upd_done and window close on the same edge: done wins, state->IDLE, no upd_abort.
REQ-017 DONE SHALL block any further grant until window close, then ->IDLE; at most one grant per frame.
REQ-018 upd_done while IDLE or DONE SHALL be ignored.
REQ-019 upd_grant SHALL never be 1 while video_on=1.

Reset
REQ-020 reset=1 at a clk edge SHALL force h_count=0, v_count=0, hsync=1, vsync=1, video_on=1, frame_start=0, upd_grant=0, upd_abort=0, FSMs V_ACT/IDLE, regardless of prior state (including mid-grant, no abort pulse).
REQ-021 First count increment SHALL occur on the first edge with reset=0.

Verification
REQ-022 Free-run 2 frames after reset -> 800 clks/line, 525 lines/frame, frame_start period 420000 clks, hsync low 96 clks starting h=656, vsync low 1600 clks starting v=490.
REQ-023 upd_req=1 at (100,200) held -> upd_grant rises at (1,480), never during video_on.
REQ-024 Grant at (1,480), upd_done pulse at (10,485) -> upd_grant falls at (11,485); upd_req kept high -> no regrant before (0,0) of next frame.
REQ-025 Grant held with no upd_done -> upd_grant falls and upd_abort=1 for one cycle at (0,0), frame_start=1 same cycle.
REQ-026 upd_done at (799,524) while granted -> grant drops at (0,0), upd_abort stays 0.
REQ-027 reset pulse at (300,500) while granted -> next cycle counts (0,0), upd_grant=0, upd_abort=0, frame_start=0, video_on=1.

Source files
------------

// File: rtl/vga_timing_controller.sv
// 640x480@60 VGA raster timing with a vblank-only framebuffer update grant.
// Sync/blank outputs are registered from next-state counts so they align with h_count/v_count.
module vga_timing_controller #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       upd_req,
    input  logic       upd_done,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_start,
    output logic       upd_grant,
    output logic       upd_abort
);

    localparam logic [9:0] H_MAX    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_MAX    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        VS_ACT,
        VS_FP,
        VS_SYNC,
        VS_BP
    } vphase_t;

    typedef enum logic [1:0] {
        G_IDLE,
        G_GRANTED,
        G_DONE
    } gstate_t;

    vphase_t    vphase, vphase_next;
    gstate_t    gstate, gstate_next;
    logic [9:0] h_next, v_next;
    logic       h_end, v_end, frame_end, in_window;
    logic       hsync_next, vsync_next, video_on_next, abort_next;

    assign h_end     = (h_count == H_MAX);
    assign v_end     = (v_count == V_MAX);
    assign frame_end = h_end && v_end;
    assign in_window = (vphase != VS_ACT);

    always_comb begin
        h_next = h_end ? 10'd0 : h_count + 10'd1;
        v_next = v_count;
        if (h_end) begin
            v_next = v_end ? 10'd0 : v_count + 10'd1;
        end
    end

    // Phase tracks v_next so it changes on the same edge as v_count.
    always_comb begin
        vphase_next = VS_BP;
        if (v_next < V_VIS) begin
            vphase_next = VS_ACT;
        end else if (v_next < VS_START) begin
            vphase_next = VS_FP;
        end else if (v_next < VS_END) begin
            vphase_next = VS_SYNC;
        end
    end

    always_comb begin
        hsync_next    = !((h_next >= HS_START) && (h_next < HS_END));
        vsync_next    = (vphase_next != VS_SYNC);
        video_on_next = (h_next < H_VIS) && (vphase_next == VS_ACT);
    end

    // Window close (edge into (0,0)) overrides everything; a same-edge done suppresses abort.
    always_comb begin
        gstate_next = gstate;
        abort_next  = 1'b0;
        unique case (gstate)
            G_IDLE: begin
                if (upd_req && in_window && !frame_end) begin
                    gstate_next = G_GRANTED;
                end
            end
            G_GRANTED: begin
                if (frame_end) begin
                    gstate_next = G_IDLE;
                    abort_next  = !upd_done;
                end else if (upd_done || !upd_req) begin
                    gstate_next = G_DONE;
                end
            end
            G_DONE: begin
                if (frame_end) begin
                    gstate_next = G_IDLE;
                end
            end
            default: gstate_next = G_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_count     <= 10'd0;
            v_count     <= 10'd0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b1;
            frame_start <= 1'b0;
            upd_grant   <= 1'b0;
            upd_abort   <= 1'b0;
            vphase      <= VS_ACT;
            gstate      <= G_IDLE;
        end else begin
            h_count     <= h_next;
            v_count     <= v_next;
            hsync       <= hsync_next;
            vsync       <= vsync_next;
            video_on    <= video_on_next;
            frame_start <= frame_end;
            upd_grant   <= (gstate_next == G_GRANTED);
            upd_abort   <= abort_next;
            vphase      <= vphase_next;
            gstate      <= gstate_next;
        end
    end

endmodule
